// File: rtl/cmp_serial_seq_pkg.sv
// cmp_pkg: shared types and width helpers for the serial magnitude comparator.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   NPAIRS()  : number of 2-bit pairs in a WIDTH-bit operand
//   IDX_W()   : width of the pair index (at least 1 bit so WIDTH=2 still elaborates)
//   CNT_W()   : width of the pair counter / npairs result
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int NPAIRS(input int width);
    return width / 2;
  endfunction

  function automatic int IDX_W(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

  function automatic int CNT_W(input int width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/cmp_serial_seq_if.sv
// cmp_serial_seq_if: start/busy/done handshake plus operand and result bus.
//   master : controller side (drives start, abort, a, b; reads results)
//   slave  : comparator side (reads request, drives busy, done and results)
interface cmp_serial_seq_if #(
  parameter int WIDTH = 8
);

  logic                             start;
  logic                             abort;
  logic [WIDTH-1:0]                 a;
  logic [WIDTH-1:0]                 b;
  logic                             busy;
  logic                             done;
  logic                             eq_out;
  logic                             gt_out;
  logic                             lt_out;
  logic [cmp_pkg::CNT_W(WIDTH)-1:0] npairs;

  modport master (
    output start, abort, a, b,
    input  busy, done, eq_out, gt_out, lt_out, npairs
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, eq_out, gt_out, lt_out, npairs
  );

endinterface

// File: rtl/cmp_serial_seq_tcs.sv
// tcs: 2-bit cascadable magnitude-compare cell.
//   i_a1/i_a0, i_b1/i_b0 : current bit pair of A and B (1 = more significant)
//   i_eq, i_gt           : result of all more-significant pairs
//   o_eq, o_gt           : result including this pair
// Once a more-significant pair has decided (i_eq=0) the incoming verdict
// passes through untouched.
module tcs (
  input  logic i_a1,
  input  logic i_a0,
  input  logic i_b1,
  input  logic i_b0,
  input  logic i_eq,
  input  logic i_gt,
  output logic o_eq,
  output logic o_gt
);

  logic w_pair_eq;
  logic w_pair_gt;

  assign w_pair_eq = ({i_a1, i_a0} == {i_b1, i_b0});
  assign w_pair_gt = ({i_a1, i_a0} >  {i_b1, i_b0});

  assign o_eq = i_eq & w_pair_eq;
  assign o_gt = i_gt | (i_eq & w_pair_gt);

endmodule

// File: rtl/cmp_serial_seq.sv
// cmp_serial_seq: multi-cycle magnitude comparator that walks the operands two
// bits per cycle from the MSB pair down through one shared tcs cell and stops
// as soon as the result is decided.
//   clk, rst : clock, synchronous active-high reset
//   cmp_if   : slave modport -- start/abort/a/b in; busy/done/eq_out/gt_out/
//              lt_out/npairs out. Results hold until the next completion.
module cmp_serial_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  cmp_serial_seq_if.slave cmp_if
);

  localparam int NP       = NPAIRS(WIDTH);
  localparam int LP_IDX_W = IDX_W(WIDTH);
  localparam int LP_CNT_W = CNT_W(WIDTH);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("cmp_serial_seq: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_acc_eq;
  logic                  r_acc_gt;
  logic [LP_IDX_W-1:0]   r_idx;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic                  r_eq;
  logic                  r_gt;
  logic                  r_lt;
  logic [LP_CNT_W-1:0]   r_npairs;

  logic                  w_accept;
  logic                  w_step;
  logic                  w_finish;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_tcs_eq;
  logic                  w_tcs_gt;
  logic [1:0]            w_a_sel;
  logic [1:0]            w_b_sel;
  logic [1:0]            w_a_pairs [NP];
  logic [1:0]            w_b_pairs [NP];

  // Split the captured operands into pairs; r_idx picks the pair under test.
  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_pair
      assign w_a_pairs[gi] = r_a[2*gi +: 2];
      assign w_b_pairs[gi] = r_b[2*gi +: 2];
    end
  endgenerate

  assign w_a_sel = w_a_pairs[r_idx];
  assign w_b_sel = w_b_pairs[r_idx];

  tcs u_tcs (
    .i_a1 (w_a_sel[1]),
    .i_a0 (w_a_sel[0]),
    .i_b1 (w_b_sel[1]),
    .i_b0 (w_b_sel[0]),
    .i_eq (r_acc_eq),
    .i_gt (r_acc_gt),
    .o_eq (w_tcs_eq),
    .o_gt (w_tcs_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Abort outranks completion; start is only looked at in IDLE and DONE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmp_if.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (cmp_if.abort) begin
          w_state_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (!w_tcs_eq || r_idx == '0) begin
            w_finish     = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (cmp_if.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc_eq <= 1'b0;
      r_acc_gt <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_npairs <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= cmp_if.a;
        r_b      <= cmp_if.b;
        r_acc_eq <= 1'b1;
        r_acc_gt <= 1'b0;
        r_idx    <= LP_IDX_W'(NP - 1);
        r_cnt    <= '0;
      end else if (w_step) begin
        r_acc_eq <= w_tcs_eq;
        r_acc_gt <= w_tcs_gt;
        // Counter stops at NP: the last step of a compare is its final one.
        r_cnt    <= r_cnt + LP_CNT_W'(1);
        if (!w_finish) begin
          r_idx <= r_idx - LP_IDX_W'(1);
        end
      end

      if (w_finish) begin
        r_eq     <= w_tcs_eq;
        r_gt     <= w_tcs_gt;
        r_lt     <= ~w_tcs_eq & ~w_tcs_gt;
        r_npairs <= r_cnt + LP_CNT_W'(1);
      end
    end
  end

  assign cmp_if.busy   = w_busy;
  assign cmp_if.done   = w_done;
  assign cmp_if.eq_out = r_eq;
  assign cmp_if.gt_out = r_gt;
  assign cmp_if.lt_out = r_lt;
  assign cmp_if.npairs = r_npairs;

endmodule
